// File: rtl/tensor_pkg.sv
// Shared constants, operation codes and sequencer state encoding for the 3x3 tensor-core datapath.
package tensor_pkg;

  localparam int BUS_WIDTH  = 7;
  localparam int MATRIX_DIM = 3;
  localparam int ELEM_COUNT = MATRIX_DIM * MATRIX_DIM;

  localparam logic [1:0] OP_MATMUL = 2'b00;
  localparam logic [1:0] OP_ADD    = 2'b01;
  localparam logic [1:0] OP_RELU   = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SYNC,
    ST_START,
    ST_RUN,
    ST_DRAIN
  } seq_state_t;

  // Row-major flat index to matrix coordinates.
  function automatic logic [1:0] elem_row(input logic [3:0] elem);
    return 2'(elem / 4'd3);
  endfunction

  function automatic logic [1:0] elem_col(input logic [3:0] elem);
    return 2'(elem % 4'd3);
  endfunction

endpackage

// File: rtl/small_tensor_core.sv
// Minimal 3x3 tensor core: write_enable idles it, start registers matmul/add/relu of the operands.
module small_tensor_core
  import tensor_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      write_enable,
  input  logic                      start,
  input  logic [1:0]                operation,
  input  logic signed [BUS_WIDTH:0] input1 [MATRIX_DIM][MATRIX_DIM],
  input  logic signed [BUS_WIDTH:0] input2 [MATRIX_DIM][MATRIX_DIM],
  output logic signed [BUS_WIDTH:0] result [MATRIX_DIM][MATRIX_DIM]
);

  logic signed [BUS_WIDTH:0] computed [MATRIX_DIM][MATRIX_DIM];

  // Arithmetic stays at element width, so sums wrap exactly like the hardware would.
  always_comb begin
    logic signed [BUS_WIDTH:0] acc;
    acc = '0;
    for (int r = 0; r < MATRIX_DIM; r++) begin
      for (int c = 0; c < MATRIX_DIM; c++) begin
        acc = '0;
        if (operation == OP_MATMUL) begin
          for (int k = 0; k < MATRIX_DIM; k++) acc = acc + input1[r][k] * input2[k][c];
        end else if (operation == OP_ADD) begin
          acc = input1[r][c] + input2[r][c];
        end else if (!input1[r][c][BUS_WIDTH]) begin
          acc = input1[r][c];
        end
        computed[r][c] = acc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || write_enable) begin
      for (int r = 0; r < MATRIX_DIM; r++)
        for (int c = 0; c < MATRIX_DIM; c++) result[r][c] <= '0;
    end else if (start) begin
      for (int r = 0; r < MATRIX_DIM; r++)
        for (int c = 0; c < MATRIX_DIM; c++) result[r][c] <= computed[r][c];
    end
  end

endmodule

// File: rtl/tensor_result_buffer.sv
// Nine-entry result store: filled from the core while running, read back while draining.
module tensor_result_buffer
  import tensor_pkg::*;
#(
  parameter int WIDTH = BUS_WIDTH + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [3:0]              wr_idx,
  input  logic signed [WIDTH-1:0] wr_data,
  input  logic [3:0]              rd_idx,
  output logic signed [WIDTH-1:0] rd_data
);

  logic signed [WIDTH-1:0] mem [ELEM_COUNT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ELEM_COUNT; i++) mem[i] <= '0;
    end else if (wr_en && (wr_idx < 4'(ELEM_COUNT))) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Out-of-range reads happen harmlessly on the final beat's lookahead.
  assign rd_data = (rd_idx < 4'(ELEM_COUNT)) ? mem[rd_idx] : '0;

endmodule

// File: rtl/tensor_core_sequencer.sv
// Streams operands into a 3x3 tensor core, runs one operation, and streams the nine results back out.
module tensor_core_sequencer
  import tensor_pkg::*;
#(
  parameter int BUS_WIDTH = tensor_pkg::BUS_WIDTH
) (
  input  logic                      tensor_core_clock,
  input  logic                      reset_in,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_operation,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic signed [BUS_WIDTH:0] load_data,
  output logic                      result_valid,
  input  logic                      result_ready,
  output logic signed [BUS_WIDTH:0] result_data,
  output logic                      result_last,
  output logic                      core_write_enable,
  output logic                      core_start,
  output logic [1:0]                core_operation,
  output logic signed [BUS_WIDTH:0] core_input1 [MATRIX_DIM][MATRIX_DIM],
  output logic signed [BUS_WIDTH:0] core_input2 [MATRIX_DIM][MATRIX_DIM],
  input  logic signed [BUS_WIDTH:0] core_output [MATRIX_DIM][MATRIX_DIM]
);

  localparam logic [4:0] LAST_LOAD = 5'(2 * ELEM_COUNT - 1);
  localparam logic [3:0] LAST_ELEM = 4'(ELEM_COUNT - 1);

  seq_state_t state, state_next;
  logic [4:0] load_idx;
  logic [3:0] load_elem;
  logic [3:0] cap_idx;
  logic [3:0] out_idx;
  logic [3:0] rd_idx;
  logic signed [BUS_WIDTH:0] rd_data;

  assign load_elem = (load_idx >= 5'(ELEM_COUNT)) ? 4'(load_idx - 5'(ELEM_COUNT)) : load_idx[3:0];
  // Read one entry ahead once a beat is presented, so the next beat is ready at the handshake.
  assign rd_idx = result_valid ? out_idx + 4'd1 : out_idx;

  always_comb begin
    state_next        = state;
    cmd_ready         = 1'b0;
    load_ready        = 1'b0;
    core_write_enable = 1'b0;
    core_start        = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        load_ready = 1'b1;
        if (load_valid && (load_idx == LAST_LOAD)) state_next = ST_SYNC;
      end
      ST_SYNC: begin
        core_write_enable = 1'b1;
        state_next        = ST_START;
      end
      ST_START: begin
        core_start = 1'b1;
        state_next = ST_RUN;
      end
      ST_RUN: begin
        if (cap_idx == LAST_ELEM) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (result_valid && result_ready && result_last) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge tensor_core_clock or posedge reset_in) begin
    if (reset_in) begin
      state          <= ST_IDLE;
      load_idx       <= '0;
      cap_idx        <= '0;
      out_idx        <= '0;
      core_operation <= OP_MATMUL;
      result_valid   <= 1'b0;
      result_last    <= 1'b0;
      result_data    <= '0;
      for (int r = 0; r < MATRIX_DIM; r++) begin
        for (int c = 0; c < MATRIX_DIM; c++) begin
          core_input1[r][c] <= '0;
          core_input2[r][c] <= '0;
        end
      end
    end else begin
      state <= state_next;
      if (cmd_ready && cmd_valid) begin
        core_operation <= cmd_operation;
        load_idx       <= '0;
      end
      if (load_ready && load_valid) begin
        load_idx <= load_idx + 5'd1;
        if (load_idx < 5'(ELEM_COUNT))
          core_input1[elem_row(load_elem)][elem_col(load_elem)] <= load_data;
        else
          core_input2[elem_row(load_elem)][elem_col(load_elem)] <= load_data;
      end
      if (state == ST_START) cap_idx <= '0;
      if (state == ST_RUN) cap_idx <= cap_idx + 4'd1;
      // Result outputs are registered: the first beat appears one cycle into DRAIN.
      if (state == ST_DRAIN) begin
        if (!result_valid) begin
          result_valid <= 1'b1;
          result_data  <= rd_data;
          result_last  <= 1'b0;
        end else if (result_ready) begin
          if (result_last) begin
            result_valid <= 1'b0;
            result_last  <= 1'b0;
            out_idx      <= '0;
          end else begin
            out_idx     <= out_idx + 4'd1;
            result_data <= rd_data;
            result_last <= (out_idx == LAST_ELEM - 4'd1);
          end
        end
      end
    end
  end

  tensor_result_buffer #(
    .WIDTH(BUS_WIDTH + 1)
  ) u_result_buffer (
    .clk    (tensor_core_clock),
    .rst    (reset_in),
    .wr_en  (state == ST_RUN),
    .wr_idx (cap_idx),
    .wr_data(core_output[elem_row(cap_idx)][elem_col(cap_idx)]),
    .rd_idx (rd_idx),
    .rd_data(rd_data)
  );

endmodule

// File: tb/tb_tensor_core_sequencer.sv
// Directed bench: sequencer wired to small_tensor_core, each result stream checked against hand-computed vectors.
module tb_tensor_core_sequencer;
  import tensor_pkg::*;

  logic clk = 1'b0;
  logic reset_in = 1'b0;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [1:0] cmd_operation = 2'b00;
  logic load_valid = 1'b0;
  logic load_ready;
  logic signed [7:0] load_data = '0;
  logic result_valid;
  logic result_ready = 1'b0;
  logic signed [7:0] result_data;
  logic result_last;
  logic core_write_enable;
  logic core_start;
  logic [1:0] core_operation;
  logic signed [7:0] core_input1 [3][3];
  logic signed [7:0] core_input2 [3][3];
  logic signed [7:0] core_output [3][3];

  int check_count = 0;
  int pass_count = 0;
  int cycle_count = 0;
  int accept_count = 0;

  int mat_ident[9] = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
  int mat_seq[9]   = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
  int mat_three[9] = '{3, 3, 3, 3, 3, 3, 3, 3, 3};
  int mat_m5[9]    = '{-5, -5, -5, -5, -5, -5, -5, -5, -5};
  int mat_relu[9]  = '{-1, 2, -3, 4, -5, 6, -7, 8, -9};
  int exp_add[9]   = '{-2, -2, -2, -2, -2, -2, -2, -2, -2};
  int exp_relu[9]  = '{0, 2, 0, 4, 0, 6, 0, 8, 0};
  int exp_square[9] = '{30, 36, 42, 66, 81, 96, 102, 126, -106};

  tensor_core_sequencer u_dut (
    .tensor_core_clock(clk),
    .reset_in         (reset_in),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_operation    (cmd_operation),
    .load_valid       (load_valid),
    .load_ready       (load_ready),
    .load_data        (load_data),
    .result_valid     (result_valid),
    .result_ready     (result_ready),
    .result_data      (result_data),
    .result_last      (result_last),
    .core_write_enable(core_write_enable),
    .core_start       (core_start),
    .core_operation   (core_operation),
    .core_input1      (core_input1),
    .core_input2      (core_input2),
    .core_output      (core_output)
  );

  small_tensor_core u_core (
    .clk         (clk),
    .rst         (reset_in),
    .write_enable(core_write_enable),
    .start       (core_start),
    .operation   (core_operation),
    .input1      (core_input1),
    .input2      (core_input2),
    .result      (core_output)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cycle_count <= cycle_count + 1;
    if (cmd_valid && cmd_ready && !reset_in) accept_count <= accept_count + 1;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    check_count++;
    if (observed == expected) pass_count++;
    else $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
  endtask

  task automatic sendCommand(input logic [1:0] op, input bit hold, input string name);
    int guard;
    guard = 0;
    while (!cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checkOutput({name, " cmd_ready"}, int'(cmd_ready), 1);
    cmd_operation = op;
    cmd_valid = 1'b1;
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic loadOperands(input int a[9], input int b[9], input bit gaps,
                              output int last_load, input string name);
    int beat;
    int guard;
    beat = 0;
    guard = 0;
    last_load = 0;
    while (beat < 18 && guard < 200) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        load_valid = 1'b0;
      end else begin
        load_valid = 1'b1;
        load_data = 8'((beat < 9) ? a[beat] : b[beat - 9]);
      end
      if (load_valid && load_ready) begin
        beat++;
        if (beat == 18) last_load = cycle_count + 1;
      end
      @(negedge clk);
      guard++;
    end
    load_valid = 1'b0;
    checkOutput({name, " load beats"}, beat, 18);
  endtask

  // Called in the SYNC cycle; leaves the bench in the START cycle.
  task automatic checkCoreControl(input logic [1:0] op, input int a0, input int b8, input string name);
    checkOutput({name, " sync write_enable"}, int'(core_write_enable), 1);
    checkOutput({name, " sync start"}, int'(core_start), 0);
    checkOutput({name, " sync load_ready"}, int'(load_ready), 0);
    checkOutput({name, " sync cmd_ready"}, int'(cmd_ready), 0);
    checkOutput({name, " operation"}, int'(core_operation), int'(op));
    checkOutput({name, " input1[0][0]"}, int'(core_input1[0][0]), a0);
    checkOutput({name, " input2[2][2]"}, int'(core_input2[2][2]), b8);
    @(negedge clk);
    checkOutput({name, " start pulse"}, int'(core_start), 1);
    checkOutput({name, " start write_enable"}, int'(core_write_enable), 0);
  endtask

  task automatic drainResults(input int expected[9], input bit backpressure,
                              input int last_load, input string name);
    int beat;
    int guard;
    int first_valid;
    bit toggle;
    beat = 0;
    guard = 0;
    first_valid = -1;
    toggle = 1'b0;
    while (beat < 9 && guard < 100) begin
      @(negedge clk);
      guard++;
      if (result_valid) begin
        if (first_valid < 0) begin
          first_valid = cycle_count;
          checkOutput({name, " latency"}, first_valid - last_load, 12);
        end
        checkOutput($sformatf("%s data[%0d]", name, beat), int'(result_data), expected[beat]);
        checkOutput($sformatf("%s last[%0d]", name, beat), int'(result_last), (beat == 8) ? 1 : 0);
        result_ready = backpressure ? toggle : 1'b1;
        if (result_ready) beat++;
      end else begin
        if (first_valid >= 0) checkOutput({name, " valid gap"}, int'(result_valid), 1);
        result_ready = backpressure ? toggle : 1'b1;
      end
      toggle = !toggle;
    end
    checkOutput({name, " result beats"}, beat, 9);
    @(negedge clk);
    result_ready = 1'b0;
    checkOutput({name, " valid after last"}, int'(result_valid), 0);
    checkOutput({name, " cmd_ready after last"}, int'(cmd_ready), 1);
  endtask

  task automatic applyStimulus(input logic [1:0] op, input int a[9], input int b[9],
                               input int expected[9], input bit gaps, input bit backpressure,
                               input bit send_cmd, input bit hold_cmd, input string name);
    int last_load;
    if (send_cmd) sendCommand(op, hold_cmd, name);
    else cmd_valid = hold_cmd;
    loadOperands(a, b, gaps, last_load, name);
    checkCoreControl(op, a[0], b[8], name);
    drainResults(expected, backpressure, last_load, name);
  endtask

  initial begin
    int acc_before;
    int last_load;
    bit saw_valid;

    #2 reset_in = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset cmd_ready", int'(cmd_ready), 1);
    checkOutput("reset load_ready", int'(load_ready), 0);
    checkOutput("reset result_valid", int'(result_valid), 0);
    checkOutput("reset result_last", int'(result_last), 0);
    checkOutput("reset result_data", int'(result_data), 0);
    checkOutput("reset write_enable", int'(core_write_enable), 0);
    checkOutput("reset core_start", int'(core_start), 0);
    checkOutput("reset core_operation", int'(core_operation), 0);
    reset_in = 1'b0;
    #1;
    checkOutput("post-reset cmd_ready", int'(cmd_ready), 1);

    $display("[TB] matmul identity x seq");
    applyStimulus(OP_MATMUL, mat_ident, mat_seq, mat_seq, 1'b0, 1'b0, 1'b1, 1'b0, "matmul");

    $display("[TB] add with cmd_valid held high");
    acc_before = accept_count;
    applyStimulus(OP_ADD, mat_three, mat_m5, exp_add, 1'b0, 1'b0, 1'b1, 1'b1, "add_hold");
    checkOutput("add_hold accepts during run", accept_count - acc_before, 1);
    @(negedge clk);
    checkOutput("add_hold reaccept", accept_count - acc_before, 2);
    checkOutput("add_hold load_ready", int'(load_ready), 1);
    applyStimulus(OP_ADD, mat_three, mat_m5, exp_add, 1'b0, 1'b0, 1'b0, 1'b0, "add_reaccept");
    checkOutput("add_reaccept total accepts", accept_count - acc_before, 2);

    $display("[TB] relu");
    applyStimulus(OP_RELU, mat_relu, mat_seq, exp_relu, 1'b0, 1'b0, 1'b1, 1'b0, "relu");

    $display("[TB] matmul with wraparound");
    applyStimulus(OP_MATMUL, mat_seq, mat_seq, exp_square, 1'b0, 1'b0, 1'b1, 1'b0, "square");

    $display("[TB] load gaps and result backpressure");
    applyStimulus(OP_MATMUL, mat_ident, mat_seq, mat_seq, 1'b1, 1'b1, 1'b1, 1'b0, "backpressure");

    $display("[TB] reset during RUN");
    sendCommand(OP_MATMUL, 1'b0, "abort");
    loadOperands(mat_ident, mat_seq, 1'b0, last_load, "abort");
    repeat (6) @(negedge clk);
    reset_in = 1'b1;
    #1;
    checkOutput("abort cmd_ready", int'(cmd_ready), 1);
    checkOutput("abort result_valid", int'(result_valid), 0);
    checkOutput("abort input1 cleared", int'(core_input1[0][0]), 0);
    checkOutput("abort input2 cleared", int'(core_input2[2][2]), 0);
    @(negedge clk);
    reset_in = 1'b0;
    saw_valid = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (result_valid) saw_valid = 1'b1;
    end
    checkOutput("abort no partial results", int'(saw_valid), 0);
    checkOutput("abort idle cmd_ready", int'(cmd_ready), 1);

    applyStimulus(OP_MATMUL, mat_ident, mat_seq, mat_seq, 1'b0, 1'b0, 1'b1, 1'b0, "after_abort");

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
